// File: rtl/pulpino_bringup_stub.sv
// rtl/pulpino_bringup_stub.sv - board bring-up stand-in for the PULPino core
//
// Purpose:
//   Occupies the core instance slot in the CW305 top level. Drives GPIO from
//   one of four runtime modes and sends a periodic UART heartbeat byte
//   (an incrementing sequence number) with CTS flow control.
//
// Ports:
//   clk, rst_n      clock (rising edge) and asynchronous active-low reset
//   mode_i[1:0]     00 OFF, 01 LOOPBACK, 10 WALK, 11 COUNT
//   gpio_dir        per-bit output enable; 0 forces the gpio_out bit to 0
//   gpio_in         GPIO input pins (used by LOOPBACK)
//   gpio_out        registered GPIO output
//   uart_tx         8N1 transmit, idle high
//   uart_cts        1 = receiver clear to send, sampled only between frames
//   uart_rx/dsr     present for port compatibility, ignored
//   uart_rts/dtr    held at 1 once out of reset

module pulpino_bringup_stub #(
   parameter int GPIO_W      = 32,
   parameter int CLK_DIV     = 16,
   parameter int HB_PERIOD   = 1024,
   parameter int PATTERN_DIV = 256
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [1:0]        mode_i,
   input  logic [GPIO_W-1:0] gpio_dir,
   input  logic [GPIO_W-1:0] gpio_in,
   output logic [GPIO_W-1:0] gpio_out,
   output logic              uart_tx,
   input  logic              uart_rx,
   input  logic              uart_cts,
   input  logic              uart_dsr,
   output logic              uart_rts,
   output logic              uart_dtr
);

   localparam int DIV_W  = (PATTERN_DIV > 1) ? $clog2(PATTERN_DIV) : 1;
   localparam int HB_W   = (HB_PERIOD > 1) ? $clog2(HB_PERIOD) : 1;
   localparam int BAUD_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(PATTERN_DIV - 1);
   localparam logic [HB_W-1:0]   HB_LAST   = HB_W'(HB_PERIOD - 1);
   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLK_DIV - 1);

   localparam logic [1:0] MODE_OFF   = 2'b00;
   localparam logic [1:0] MODE_LOOP  = 2'b01;
   localparam logic [1:0] MODE_WALK  = 2'b10;
   localparam logic [1:0] MODE_COUNT = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } uart_state_e;

   // GPIO pattern state
   logic [1:0]        mode_q, mode_d;
   logic [DIV_W-1:0]  div_q, div_d;
   logic [GPIO_W-1:0] walk_q, walk_d;
   logic [GPIO_W-1:0] cnt_q, cnt_d;
   logic [GPIO_W-1:0] gpio_out_q, gpio_out_d;

   // heartbeat and UART state
   logic [HB_W-1:0]   hb_q, hb_d;
   logic              pend_q, pend_d;
   uart_state_e       state_q, state_d;
   logic [BAUD_W-1:0] baud_q, baud_d;
   logic [2:0]        bit_q, bit_d;
   logic [7:0]        seq_q, seq_d;
   logic              tx_q, tx_d;
   logic              rts_q, rts_d;

   logic mode_change;
   logic pat_tick;
   logic hb_tick;
   logic baud_done;
   logic frame_start;

   // uart_rx and uart_dsr exist only so the port list matches the core
   logic unused_inputs;
   assign unused_inputs = ^{uart_rx, uart_dsr};

   // -------------------------------------------------------------------------
   // GPIO pattern generation
   // -------------------------------------------------------------------------
   always_comb begin
      mode_d      = mode_i;
      mode_change = (mode_i != mode_q);
      pat_tick    = (div_q == DIV_LAST);
      div_d       = div_q;
      walk_d      = walk_q;
      cnt_d       = cnt_q;

      if (mode_change) begin
         // restart the pattern so a new mode always begins from a known value
         div_d  = '0;
         walk_d = GPIO_W'(1);
         cnt_d  = '0;
      end else begin
         div_d = pat_tick ? '0 : div_q + DIV_W'(1);
         if (pat_tick) begin
            // rotate left; the right shift brings the top bit back to bit0
            walk_d = (walk_q << 1) | (walk_q >> (GPIO_W - 1));
            cnt_d  = cnt_q + GPIO_W'(1);
         end
      end

      // output register loads the next pattern value so the entry value
      // (bit0 / zero) is visible on the first cycle of the new mode
      case (mode_i)
         MODE_OFF:   gpio_out_d = '0;
         MODE_LOOP:  gpio_out_d = gpio_in & gpio_dir;
         MODE_WALK:  gpio_out_d = walk_d & gpio_dir;
         MODE_COUNT: gpio_out_d = cnt_d & gpio_dir;
         default:    gpio_out_d = '0;
      endcase
   end

   // -------------------------------------------------------------------------
   // Heartbeat request and UART transmitter
   // -------------------------------------------------------------------------
   always_comb begin
      hb_tick     = (mode_i != MODE_OFF) && (hb_q == HB_LAST);
      hb_d        = (mode_i == MODE_OFF) ? '0 : (hb_tick ? '0 : hb_q + HB_W'(1));
      baud_done   = (baud_q == BAUD_LAST);
      frame_start = 1'b0;
      state_d     = state_q;
      baud_d      = baud_done ? '0 : baud_q + BAUD_W'(1);
      bit_d       = bit_q;
      seq_d       = seq_q;
      rts_d       = 1'b1;

      case (state_q)
         ST_IDLE: begin
            baud_d = '0;
            bit_d  = '0;
            // CTS only gates the start of a frame; once started it runs out
            if (pend_q && uart_cts && (mode_i != MODE_OFF)) begin
               frame_start = 1'b1;
               state_d     = ST_START;
            end
         end
         ST_START: begin
            if (baud_done) state_d = ST_DATA;
         end
         ST_DATA: begin
            if (baud_done) begin
               if (bit_q == 3'd7) state_d = ST_STOP;
               else               bit_d   = bit_q + 3'd1;
            end
         end
         ST_STOP: begin
            if (baud_done) begin
               state_d = ST_IDLE;
               seq_d   = seq_q + 8'd1;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // a request during a frame or while already pending merges into one;
      // a tick coinciding with a frame start survives for the next frame
      pend_d = (pend_q & ~frame_start) | hb_tick;
      if (mode_i == MODE_OFF) pend_d = 1'b0;

      // tx is registered from the next state so it changes with the state
      case (state_d)
         ST_START: tx_d = 1'b0;
         ST_DATA:  tx_d = seq_q[bit_d];
         default:  tx_d = 1'b1;
      endcase
   end

   // -------------------------------------------------------------------------
   // State registers
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mode_q     <= MODE_OFF;
         div_q      <= '0;
         walk_q     <= '0;
         cnt_q      <= '0;
         gpio_out_q <= '0;
         hb_q       <= '0;
         pend_q     <= 1'b0;
         state_q    <= ST_IDLE;
         baud_q     <= '0;
         bit_q      <= '0;
         seq_q      <= 8'h00;
         tx_q       <= 1'b1;
         rts_q      <= 1'b0;
      end else begin
         mode_q     <= mode_d;
         div_q      <= div_d;
         walk_q     <= walk_d;
         cnt_q      <= cnt_d;
         gpio_out_q <= gpio_out_d;
         hb_q       <= hb_d;
         pend_q     <= pend_d;
         state_q    <= state_d;
         baud_q     <= baud_d;
         bit_q      <= bit_d;
         seq_q      <= seq_d;
         tx_q       <= tx_d;
         rts_q      <= rts_d;
      end
   end

   assign gpio_out = gpio_out_q;
   assign uart_tx  = tx_q;
   assign uart_rts = rts_q;
   assign uart_dtr = rts_q;

endmodule

// File: tb/tb_pulpino_bringup_stub.sv
// tb/tb_pulpino_bringup_stub.sv - directed self-checking bench for pulpino_bringup_stub
module tb_pulpino_bringup_stub;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [1:0]  mode_i = 2'b00;
   logic [31:0] gpio_dir = '0;
   logic [31:0] gpio_in = '0;
   logic [31:0] gpio_out;
   logic        uart_tx;
   logic        uart_rx = 1'b1;
   logic        uart_cts = 1'b0;
   logic        uart_dsr = 1'b0;
   logic        uart_rts;
   logic        uart_dtr;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   pulpino_bringup_stub #(
      .GPIO_W(32), .CLK_DIV(4), .HB_PERIOD(64), .PATTERN_DIV(4)
   ) dut (
      .clk(clk), .rst_n(rst_n), .mode_i(mode_i),
      .gpio_dir(gpio_dir), .gpio_in(gpio_in), .gpio_out(gpio_out),
      .uart_tx(uart_tx), .uart_rx(uart_rx), .uart_cts(uart_cts),
      .uart_dsr(uart_dsr), .uart_rts(uart_rts), .uart_dtr(uart_dtr)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // poll at negedges until tx goes low; fc is the cycle count at detection
   task automatic wait_fall(input string tag, input int limit, output int fc);
      int n = 0;
      while (uart_tx !== 1'b0 && n < limit) begin
         @(negedge clk);
         n++;
      end
      fc = cyc;
      chk({tag, "_tx_fall"}, {31'd0, uart_tx}, 32'd0);
   endtask

   // decode one 8N1 frame (CLK_DIV=4), sampling two cycles into each bit
   task automatic rx_frame(input string tag, input logic [7:0] exp_byte, input int exp_fall);
      int fc;
      logic [7:0] b;
      wait_fall(tag, 100, fc);
      chk({tag, "_start_cyc"}, fc, exp_fall);
      repeat (2) @(negedge clk);
      chk({tag, "_start_bit"}, {31'd0, uart_tx}, 32'd0);
      for (int i = 0; i < 8; i++) begin
         repeat (4) @(negedge clk);
         b[i] = uart_tx;
      end
      chk({tag, "_byte"}, {24'd0, b}, {24'd0, exp_byte});
      repeat (4) @(negedge clk);
      chk({tag, "_stop_bit"}, {31'd0, uart_tx}, 32'd1);
      repeat (2) @(negedge clk);
      chk({tag, "_idle_after"}, {31'd0, uart_tx}, 32'd1);
   endtask

   initial begin
      int base;
      int rst_cyc;
      int fc;
      int lows;
      logic [31:0] one;
      one = 32'd1;

      // ---------------- reset state ----------------
      @(negedge clk);
      chk("rst_gpio", gpio_out, 32'd0);
      chk("rst_tx", {31'd0, uart_tx}, 32'd1);
      chk("rst_rts", {31'd0, uart_rts}, 32'd0);
      chk("rst_dtr", {31'd0, uart_dtr}, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rel_rts", {31'd0, uart_rts}, 32'd1);

      // ---------------- loopback ----------------
      mode_i = 2'b01; gpio_dir = 32'h0000FFFF; gpio_in = 32'hA5A55A5A;
      #1 chk("lb_before_edge", gpio_out, 32'd0);
      @(negedge clk);
      chk("lb_masked", gpio_out, 32'h00005A5A);
      gpio_dir = 32'h0; uart_rx = 1'b0; uart_dsr = 1'b1;
      @(negedge clk);
      chk("lb_dir0", gpio_out, 32'd0);
      gpio_dir = 32'hFFFFFFFF; gpio_in = 32'h12345678;
      @(negedge clk);
      chk("lb_full", gpio_out, 32'h12345678);

      // ---------------- walk, with wrap ----------------
      mode_i = 2'b10;
      @(negedge clk);
      chk("walk_entry", gpio_out, 32'h1);
      for (int k = 1; k <= 33; k++) begin
         repeat (4) @(negedge clk);
         chk($sformatf("walk_step%0d", k), gpio_out, one << (k % 32));
      end

      // ---------------- mode toggles restart patterns ----------------
      mode_i = 2'b11;
      @(negedge clk);
      chk("count_entry", gpio_out, 32'd0);
      repeat (4) @(negedge clk);
      chk("count_1", gpio_out, 32'd1);
      repeat (4) @(negedge clk);
      chk("count_2", gpio_out, 32'd2);
      mode_i = 2'b10;
      @(negedge clk);
      chk("walk_reentry", gpio_out, 32'h1);
      repeat (4) @(negedge clk);
      chk("walk_reentry_step", gpio_out, 32'h2);
      mode_i = 2'b11;
      @(negedge clk);
      repeat (4) @(negedge clk);
      chk("count_pre_rst", gpio_out, 32'd1);
      chk("tx_idle_cts0", {31'd0, uart_tx}, 32'd1);

      // ---------------- asynchronous reset mid-run ----------------
      #2 rst_n = 1'b0;
      #1;
      chk("async_gpio", gpio_out, 32'd0);
      chk("async_tx", {31'd0, uart_tx}, 32'd1);
      chk("async_rts", {31'd0, uart_rts}, 32'd0);
      chk("async_dtr", {31'd0, uart_dtr}, 32'd0);
      mode_i = 2'b00;
      @(negedge clk);
      rst_n = 1'b1;
      #1 chk("rel_rts_no_edge", {31'd0, uart_rts}, 32'd0);
      @(negedge clk);
      chk("rel_rts_1clk", {31'd0, uart_rts}, 32'd1);
      chk("rel_dtr_1clk", {31'd0, uart_dtr}, 32'd1);

      // ---------------- heartbeat frames, cts=1 ----------------
      base = cyc;
      mode_i = 2'b11; uart_cts = 1'b1;
      rx_frame("f0", 8'h00, base + 65);
      rx_frame("f1", 8'h01, base + 129);
      rx_frame("f2", 8'h02, base + 193);

      // ---------------- cts held low over three periods ----------------
      uart_cts = 1'b0;
      lows = 0;
      while (cyc < base + 400) begin
         @(negedge clk);
         if (uart_tx !== 1'b1) lows++;
      end
      chk("cts0_no_frame", lows, 0);
      uart_cts = 1'b1;
      rx_frame("f3_after_cts", 8'h03, base + 401);
      rx_frame("f4_next_hb", 8'h04, base + 449);

      // ---------------- reset during frame 0x05 data bits ----------------
      wait_fall("f5", 100, fc);
      chk("f5_start_cyc", fc, base + 513);
      repeat (10) @(negedge clk);
      chk("f5_bit1_low", {31'd0, uart_tx}, 32'd0);
      #2 rst_n = 1'b0;
      #1 chk("f5_rst_tx_high", {31'd0, uart_tx}, 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      rst_cyc = cyc;
      rx_frame("f_post_rst", 8'h00, rst_cyc + 65);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
